seq_adder: RTL and testbench

// Multi-cycle ripple-carry adder; the additive counterpart of the 32-bit borrow-chain subtractor.

---
 rtl/seq_adder.sv | 107 ++++++++++
 tb/tb_seq_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// Multi-cycle ripple-carry adder: sums two WIDTH-bit operands plus carry-in,
// CHUNK bits per clock (LSB chunk first), with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// RUN   | one CHUNK-bit slice added per edge, N edges total
// DONE  | one-cycle done pulse, then back to IDLE
module seq_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             v_out
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [WIDTH-1:0] psum;

   logic [CHUNK:0]   chunk_full;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_cout;
   logic             msb_cin;
   logic [WIDTH-1:0] psum_next;

   always_comb begin
      chunk_full = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};
      chunk_sum  = chunk_full[CHUNK-1:0];
      chunk_cout = chunk_full[CHUNK];
      // Carry into the top bit of this slice, recovered from the sum bit.
      msb_cin    = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_sum[CHUNK-1];
      psum_next  = (psum >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         psum  <= '0;
         sum   <= '0;
         c_out <= 1'b0;
         v_out <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  psum  <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               psum  <= psum_next;
               a_sh  <= a_sh >> CHUNK;
               b_sh  <= b_sh >> CHUNK;
               carry <= chunk_cout;
               count <= count + CW'(1);
               if (count == CW'(N - 1)) begin
                  sum   <= psum_next;
                  c_out <= chunk_cout;
                  v_out <= msb_cin ^ chunk_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: three instances (CHUNK 8, 1, 32) share stimulus and are
// checked every cycle against a cycle-count/arithmetic model plus literal expectations.
module tb_seq_adder;

   localparam int NS [3] = '{4, 32, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        c_in = 1'b0;

   logic        busy_w [3];
   logic        done_w [3];
   logic [31:0] sum_w  [3];
   logic        c_w    [3];
   logic        v_w    [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .c_out(c_w[0]), .v_out(v_w[0]));
   seq_adder #(.WIDTH(32), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .c_out(c_w[1]), .v_out(v_w[1]));
   seq_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
      .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .c_out(c_w[2]), .v_out(v_w[2]));

   task automatic chk(input string nm, input int k, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %h required %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: phase p counts cycles since acceptance (0 = idle); results from plain arithmetic.
   int          p  [3] = '{0, 0, 0};
   logic [31:0] es [3] = '{0, 0, 0};
   logic        ec [3] = '{0, 0, 0};
   logic        ev [3] = '{0, 0, 0};
   logic [31:0] ps [3];
   logic        pc [3];
   logic        pv [3];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            p[k] = 0; es[k] = '0; ec[k] = 1'b0; ev[k] = 1'b0;
         end else if (p[k] == 0) begin
            if (start) begin
               {pc[k], ps[k]} = {1'b0, a} + {1'b0, b} + 33'(c_in);
               pv[k] = (a[31] == b[31]) && (ps[k][31] != a[31]);
               p[k] = 1;
            end
         end else if (p[k] <= NS[k]) begin
            p[k]++;
            if (p[k] == NS[k] + 1) begin
               es[k] = ps[k]; ec[k] = pc[k]; ev[k] = pv[k];
            end
         end else begin
            p[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("busy", k, 33'(busy_w[k]), 33'(p[k] >= 1 && p[k] <= NS[k]));
         chk("done", k, 33'(done_w[k]), 33'(p[k] == NS[k] + 1));
         chk("sum",  k, 33'(sum_w[k]),  33'(es[k]));
         chk("cout", k, 33'(c_w[k]),    33'(ec[k]));
         chk("vout", k, 33'(v_w[k]),    33'(ev[k]));
      end
   end

   task automatic drive_start(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      @(negedge clk); #2;
      start = 1'b1; a = av; b = bv; c_in = cv;
   endtask

   // Runs one op long enough for the slowest instance, optionally poking start at cycle 2.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                         input logic [31:0] xs, input logic xc, input logic xv, input bit poke);
      drive_start(av, bv, cv);
      for (int cyc = 1; cyc <= 35; cyc++) begin
         @(negedge clk); #2;
         start = 1'b0;
         if (poke && cyc == 2) begin
            start = 1'b1; a = 32'd1; b = 32'd1; c_in = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         chk("lit_sum",  k, 33'(sum_w[k]), 33'(xs));
         chk("lit_cout", k, 33'(c_w[k]),   33'(xc));
         chk("lit_vout", k, 33'(v_w[k]),   33'(xv));
      end
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rc;
      logic [32:0] g;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy", k, 33'(busy_w[k]), 33'd0);
         chk("rst_sum",  k, 33'(sum_w[k]),  33'd0);
      end

      // 5 + 3 with exact latency pinned per cycle.
      drive_start(32'd5, 32'd3, 1'b0);
      for (int cyc = 1; cyc <= 35; cyc++) begin
         @(negedge clk);
         chk("lat_busy8",  0, 33'(busy_w[0]), 33'(cyc >= 1 && cyc <= 4));
         chk("lat_done8",  0, 33'(done_w[0]), 33'(cyc == 5));
         chk("lat_done1",  1, 33'(done_w[1]), 33'(cyc == 33));
         chk("lat_done32", 2, 33'(done_w[2]), 33'(cyc == 2));
         #2 start = 1'b0;
      end
      chk("lit_sum8", 0, 33'(sum_w[0]), 33'h0_0000_0008);

      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
      run_op(32'h000000FF, 32'h00000001, 1'b1, 32'h00000101, 1'b0, 1'b0, 1'b1);

      // Reset in cycle 3 of an operation.
      drive_start(32'h12345678, 32'h11111111, 1'b0);
      repeat (3) begin
         @(negedge clk); #2 start = 1'b0;
      end
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("arst_busy", k, 33'(busy_w[k]), 33'd0);
         chk("arst_done", k, 33'(done_w[k]), 33'd0);
         chk("arst_sum",  k, 33'(sum_w[k]),  33'd0);
         chk("arst_cv",   k, {31'd0, c_w[k], v_w[k]}, 33'd0);
      end
      @(negedge clk); #2 rst = 1'b0;
      run_op(32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         if (i == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; rc = 1'b0; end
         g = {1'b0, ra} + {1'b0, rb} + 33'(rc);
         run_op(ra, rb, rc, g[31:0], g[32],
                (ra[31] == rb[31]) && (g[31] != ra[31]), 1'b0);
      end

      // Start held high with operands changing every cycle: back-to-back ops.
      @(negedge clk); #2 start = 1'b1;
      for (int cyc = 0; cyc < 110; cyc++) begin
         a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
         @(negedge clk); #2;
      end
      start = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
